// File: rtl/axis_block_assembler.sv
// Packs WORDS upstream words into one BLOCK_WIDTH block (first word in the MSBs).
// One assembly register plus one output register sustain one word per cycle.
module axis_block_assembler #(
  parameter  int IN_WIDTH    = 32,
  parameter  int WORDS       = 4,
  localparam int BLOCK_WIDTH = IN_WIDTH * WORDS,
  localparam int CW          = $clog2(WORDS),
  localparam int WW          = $clog2(WORDS) + 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_wren,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic                   in_tlast,
  output logic                   in_busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BLOCK_WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic [WW-1:0]          out_words
);

  typedef enum logic {FILL, HELD} state_e;

  typedef struct packed {
    logic [BLOCK_WIDTH-1:0] data;
    logic                   last;
    logic [WW-1:0]          words;
  } blk_t;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BLOCK_WIDTH-1:0] asm_q, asm_d;
  logic                   hlast_q, hlast_d;
  logic [WW-1:0]          hwords_q, hwords_d;
  blk_t                   out_q, out_d;
  logic                   ovld_q, ovld_d;

  logic                   acc, done, free;
  logic [BLOCK_WIDTH-1:0] merged;

  always_comb begin
    acc  = in_wren && (state_q == FILL);
    free = !ovld_q || out_ready;
    done = acc && ((cnt_q == CW'(WORDS - 1)) || in_tlast);

    merged = asm_q;
    for (int k = 0; k < WORDS; k++)
      if (cnt_q == CW'(k)) merged[BLOCK_WIDTH-1-k*IN_WIDTH -: IN_WIDTH] = in_data;

    state_d  = state_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    hlast_d  = hlast_q;
    hwords_d = hwords_q;
    out_d    = out_q;
    ovld_d   = ovld_q && !out_ready;

    case (state_q)
      FILL: begin
        if (done) begin
          cnt_d = '0;
          if (free) begin
            out_d.data  = merged;
            out_d.last  = in_tlast;
            out_d.words = WW'(cnt_q) + WW'(1);
            ovld_d      = 1'b1;
            asm_d       = '0;
          end else begin
            // Completed block parks in the assembly register until the output frees up.
            state_d  = HELD;
            asm_d    = merged;
            hlast_d  = in_tlast;
            hwords_d = WW'(cnt_q) + WW'(1);
          end
        end else if (acc) begin
          cnt_d = cnt_q + CW'(1);
          asm_d = merged;
        end
      end
      HELD: begin
        if (free) begin
          out_d.data  = asm_q;
          out_d.last  = hlast_q;
          out_d.words = hwords_q;
          ovld_d      = 1'b1;
          asm_d       = '0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      asm_q    <= '0;
      hlast_q  <= 1'b0;
      hwords_q <= '0;
      out_q    <= '0;
      ovld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      hlast_q  <= hlast_d;
      hwords_q <= hwords_d;
      out_q    <= out_d;
      ovld_q   <= ovld_d;
    end
  end

  assign in_busy   = (state_q == HELD);
  assign out_valid = ovld_q;
  assign out_data  = out_q.data;
  assign out_last  = out_q.last;
  assign out_words = out_q.words;

endmodule

// File: tb/tb_axis_block_assembler.sv
// Directed bench for axis_block_assembler with a queue-based block model.
module tb_axis_block_assembler;
  logic         clk = 1'b0;
  logic         resetn;
  logic         in_wren, in_tlast, in_busy;
  logic [31:0]  in_data;
  logic         out_valid, out_ready, out_last;
  logic [127:0] out_data;
  logic [2:0]   out_words;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit busy_seen = 0;
  int takes[$];

  typedef struct {
    logic [127:0] d;
    bit           l;
    int           w;
  } eb_t;
  logic [31:0] cur[$];
  eb_t         expq[$];

  logic [127:0] prev_data;
  bit           prev_hold = 0;

  axis_block_assembler #(.IN_WIDTH(32), .WORDS(4)) dut (
    .clk(clk), .resetn(resetn),
    .in_wren(in_wren), .in_data(in_data), .in_tlast(in_tlast), .in_busy(in_busy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_words(out_words)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: accepted words gather into blocks; outstanding blocks wait in expq.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur.delete();
      expq.delete();
    end else begin
      cyc++;
      if (in_busy) busy_seen = 1;
      if (out_valid && out_ready) begin
        takes.push_back(cyc);
        if (expq.size() > 0) void'(expq.pop_front());
      end
      if (in_wren && !in_busy) begin
        cur.push_back(in_data);
        if (cur.size() == 4 || in_tlast) begin
          eb_t b;
          b.d = '0;
          for (int i = 0; i < cur.size(); i++) b.d[127-32*i -: 32] = cur[i];
          b.l = in_tlast;
          b.w = cur.size();
          expq.push_back(b);
          cur.delete();
        end
      end
    end
  end

  // Two outstanding blocks means one is parked behind a stalled output.
  always @(negedge clk) begin
    chk("busy_model", in_busy, expq.size() == 2);
    chk("valid_model", out_valid, expq.size() > 0);
    if (out_valid && expq.size() > 0) begin
      chk("data_model", out_data, expq[0].d);
      chk("last_model", out_last, expq[0].l);
      chk("words_model", out_words, 128'(expq[0].w));
    end
    if (prev_hold && out_valid) chk("stable", out_data, prev_data);
    prev_hold = out_valid && !out_ready && resetn;
    prev_data = out_data;
  end

  task automatic send(input logic [31:0] d, input bit l);
    bit ok = 0;
    in_wren = 1; in_data = d; in_tlast = l;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (!in_busy) begin ok = 1; break; end
    end
    #1;
    in_wren = 0; in_tlast = 0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: word %h never accepted", d);
    end
  endtask

  task automatic idle(input int n);
    in_wren = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 0; in_wren = 0; in_data = '0; in_tlast = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", in_busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_words", out_words, 0);
    resetn = 1;

    // Single full frame
    out_ready = 1;
    send(32'h00112233, 0); send(32'h44556677, 0);
    send(32'h8899AABB, 0); send(32'hCCDDEEFF, 1);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("single_last", out_last, 1);
    chk("single_words", out_words, 4);

    // Early tlast
    send(32'hA, 0); send(32'hB, 1);
    chk("partial_data", out_data, 128'h0000000A_0000000B_00000000_00000000);
    chk("partial_words", out_words, 2);
    chk("partial_last", out_last, 1);
    idle(3);

    // Backpressure: second block parks, ninth word waits
    out_ready = 0; takes.delete();
    for (int i = 1; i <= 8; i++) send(i, 0);
    chk("bp_busy_rise", in_busy, 1);
    in_wren = 1; in_data = 9; in_tlast = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_busy_hold", in_busy, 1);
      chk("bp_blk1", out_data, 128'h00000001_00000002_00000003_00000004);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_busy_fall", in_busy, 0);
    chk("bp_blk2", out_data, 128'h00000005_00000006_00000007_00000008);
    for (int i = 9; i <= 12; i++) send(i, 0);
    chk("bp_blk3", out_data, 128'h00000009_0000000A_0000000B_0000000C);
    idle(4);
    chk("bp_takes", takes.size(), 3);
    chk("bp_drained", out_valid, 0);

    // Throughput
    takes.delete(); busy_seen = 0;
    for (int i = 0; i < 64; i++) send(32'h100 + i, 0);
    idle(4);
    chk("tp_blocks", takes.size(), 16);
    for (int i = 1; i < takes.size(); i++) chk("tp_spacing", takes[i] - takes[i-1], 4);
    chk("tp_no_busy", busy_seen, 0);

    // Single-word frames
    send(32'h11, 1);
    chk("sw1_data", out_data, {32'h11, 96'h0});
    chk("sw1_words", out_words, 1);
    send(32'h22, 1);
    chk("sw2_data", out_data, {32'h22, 96'h0});
    chk("sw2_last", out_last, 1);
    send(32'h33, 1);
    chk("sw3_data", out_data, {32'h33, 96'h0});
    chk("sw3_words", out_words, 1);
    idle(3);

    // Mid-operation reset with a block pending and a partial in assembly
    out_ready = 0;
    for (int i = 0; i < 6; i++) send(32'h21 + i, 0);
    #2 resetn = 0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_busy", in_busy, 0);
    @(posedge clk); #1;
    resetn = 1; out_ready = 1;
    send(32'h31, 0); send(32'h32, 0); send(32'h33, 0); send(32'h34, 1);
    chk("mrst_blk", out_data, 128'h00000031_00000032_00000033_00000034);
    chk("mrst_words", out_words, 4);
    chk("mrst_last", out_last, 1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_block_assembler.md
Name: axis_block_assembler

Overview:
- Sits directly downstream of the generic AXI4-Stream slave skid buffer and consumes its FIFO-side write interface (wren/busy/data/tlast).
- Packs WORDS consecutive IN_WIDTH-bit words into one block for the AES core.
- Presents blocks on a valid/ready output with a frame-last flag and a valid-word count.
- Double-buffered: one assembly register plus one output register, so a continuous one-word-per-cycle stream is sustained while out_ready stays high.

Parameters:
- IN_WIDTH, 32, width of input words; must match the upstream AXIS_TDATA_WIDTH.
- WORDS, 4, words per block; must be at least 2. BLOCK_WIDTH = IN_WIDTH*WORDS (128 by default).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- in_wren  in  1  upstream word valid (upstream fifo_wren).
- in_data  in  IN_WIDTH  upstream word (upstream fifo_data).
- in_tlast  in  1  the word is the last of the frame (upstream stream_tlast).
- in_busy  out  1  backpressure to upstream (drives upstream fifo_busy).
- out_valid  out  1  block available.
- out_ready  in  1  downstream accepts the block.
- out_data  out  BLOCK_WIDTH  assembled block.
- out_last  out  1  block closes the frame.
- out_words  out  $clog2(WORDS)+1  number of valid words in the block, 1..WORDS.

Behaviour:
- Word accept: acc = in_wren && !in_busy. Block accept: take = out_valid && out_ready.
- Packing order: word index k (0-based, first word = 0) goes to asm_data[BLOCK_WIDTH-1-k*IN_WIDTH -: IN_WIDTH], so the first word lands in the MSBs.
- cnt counts words already held, 0..WORDS-1.
- A block completes on the acc cycle where cnt==WORDS-1 or in_tlast==1.
- On an early tlast, unfilled word slots are zero, words = cnt+1, and last = 1. A full block that is not frame-final has last = 0.
- After a block completes, cnt resets to 0 and asm_data is cleared to zero for the next block.
- Assembly state machine:
  - FILL: accepting words.
  - HELD: a completed block is waiting for the output register.
  - FILL -> HELD when a block completes while the output register is occupied and not draining (out_valid && !out_ready).
  - Otherwise a completing block loads the output register directly at the next edge and FILL is kept.
  - HELD -> FILL when the output register becomes free (!out_valid or take); the held block moves to the output register on that edge.
- in_busy = (state == HELD). It is registered-state only: no combinational path from in_wren or out_ready.
- Output register:
  - out_valid sets when a block loads.
  - out_valid clears on take with no simultaneous load.
  - Take and load in the same cycle keeps out_valid high with the new contents.
- out_data, out_last and out_words are stable while out_valid && !out_ready.
- Latency: the completing word accepted at edge N gives out_valid=1 after edge N, provided the output register is free or draining. Steady throughput is 1 word per cycle with out_ready held at 1.
- A word arriving while in HELD is not accepted (in_busy=1); upstream holds it.
- A tlast on the very first word gives a block with out_words=1.
- Consecutive frames never share a block.
- Reset values (asynchronous, immediate on resetn low):
  - in_busy=0, out_valid=0, out_data=0, out_last=0, out_words=0.
  - cnt=0, asm_data=0, state=FILL.
- A partial block held at reset is discarded with no output.
- After resetn releases, the first edge may accept a word.
- The cnt wrap WORDS-1 -> 0 and the HELD transition on the same edge must both take effect; there is no lost or duplicated word.

Test Plan:
- Single block: words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, tlast on the 4th, out_ready=1 -> one cycle after the 4th accept, out_data=0x00112233_44556677_8899AABB_CCDDEEFF, out_last=1, out_words=4; in_busy stays 0 throughout.
- Partial frame: words 0xA, 0xB with tlast on 0xB -> out_data=0x0000000A_0000000B_00000000_00000000, out_words=2, out_last=1.
- Backpressure: out_ready=0, stream 12 words back to back -> the first block stays valid and stable; the second block completes and in_busy rises the cycle after the 8th accept; the 9th word is held. Raise out_ready -> blocks 1, 2, 3 are emitted in order with no loss, and in_busy falls the cycle after the first take.
- Throughput: 64 words with in_wren=1 and out_ready=1 -> exactly 16 blocks; in_busy never asserted; blocks emitted every 4 cycles.
- Single-word frames: 3 words each carrying tlast -> 3 blocks, each with out_words=1, out_last=1, and its word in the MSBs.
- Mid-operation reset: assert resetn=0 after 2 words of a block -> out_valid=0 immediately; the next 4 words after release form a clean block with no stale data.
